// File: rtl/counter_stream_monitor.sv
// ---------------------------------------------------------------------------
// counter_stream_monitor
//
// Receive-side checker for the count bus of a partially reconfigurable
// counter region. The bus is sampled every clock and each change of value is
// classified as an up step (+1), a down step (-1) or an illegal jump. All
// steps wrap modulo 2^WIDTH. The monitor locks onto the running direction
// after LOCK_STEPS consecutive steps in the same direction. It also reports
// the following events:
//   - illegal jumps,
//   - stalls (no change for TIMEOUT clocks),
//   - direction swaps, which happen when a new bitstream reverses the counter.
// While decouple is high the bus is ignored. The first sample after decouple
// is released is taken as a fresh baseline.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   count_in   in   [WIDTH-1:0] monitored count bus
//   decouple   in   region under reconfiguration; count_in is don't-care
//   locked     out  direction lock established
//   dir_up     out  locked and counting up
//   dir_down   out  locked and counting down
//   step_err   out  one-cycle pulse on an illegal jump
//   stall      out  one-cycle pulse on timeout
//   swap_seen  out  one-cycle pulse when a locked stream reverses direction
//   err_count  out  [7:0] saturating count of step_err pulses
//   last_value out  [WIDTH-1:0] most recent accepted count_in
// ---------------------------------------------------------------------------
module counter_stream_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 3,
    parameter int TIMEOUT    = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             decouple,
    output logic             locked,
    output logic             dir_up,
    output logic             dir_down,
    output logic             step_err,
    output logic             stall,
    output logic             swap_seen,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] last_value
);

    typedef enum logic [1:0] {
        BASELINE  = 2'd0,
        SYNC      = 2'd1,
        LOCK_UP   = 2'd2,
        LOCK_DOWN = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      gap_q, gap_d;
    logic [3:0]       run_q, run_d;
    logic             run_up_q, run_up_d;     // direction of the current run
    logic [WIDTH-1:0] last_q, last_d;
    logic [7:0]       err_q, err_d;
    logic             step_err_q, step_err_d;
    logic             stall_q, stall_d;
    logic             swap_q, swap_d;

    // Step classification against the held reference value.
    logic             changed;
    logic             is_up;
    logic             is_down;
    logic [3:0]       run_inc;

    assign changed = (count_in != last_q);
    assign is_up   = (count_in == WIDTH'(last_q + WIDTH'(1)));
    assign is_down = (count_in == WIDTH'(last_q - WIDTH'(1))) && !is_up;
    // The run continues only if it is non-empty and points the same way.
    assign run_inc = ((run_q != 4'd0) && (run_up_q == is_up)) ? 4'(run_q + 4'd1) : 4'd1;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BASELINE;
            gap_q      <= '0;
            run_q      <= '0;
            run_up_q   <= 1'b0;
            last_q     <= '0;
            err_q      <= '0;
            step_err_q <= 1'b0;
            stall_q    <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            run_q      <= run_d;
            run_up_q   <= run_up_d;
            last_q     <= last_d;
            err_q      <= err_d;
            step_err_q <= step_err_d;
            stall_q    <= stall_d;
            swap_q     <= swap_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        run_d      = run_q;
        run_up_d   = run_up_q;
        last_d     = last_q;
        err_d      = err_q;
        step_err_d = 1'b0;
        stall_d    = 1'b0;
        swap_d     = 1'b0;

        if (decouple) begin
            // Decouple overrides everything. The reference is kept for
            // observation but is replaced by the next baseline sample.
            state_d = BASELINE;
            gap_d   = '0;
            run_d   = '0;
        end else if (state_q == BASELINE) begin
            last_d  = count_in;
            gap_d   = '0;
            run_d   = '0;
            state_d = SYNC;
        end else if (changed) begin
            // A change always wins over a coincident timeout.
            last_d = count_in;
            gap_d  = '0;
            if (is_up || is_down) begin
                if (state_q == SYNC) begin
                    run_d    = run_inc;
                    run_up_d = is_up;
                    if (run_inc == 4'(LOCK_STEPS)) begin
                        state_d = is_up ? LOCK_UP : LOCK_DOWN;
                    end
                end else if ((state_q == LOCK_UP) != is_up) begin
                    // Locked stream reversed: restart the run in the new direction.
                    swap_d   = 1'b1;
                    state_d  = SYNC;
                    run_d    = 4'd1;
                    run_up_d = is_up;
                end
            end else begin
                step_err_d = 1'b1;
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
                run_d   = '0;
                state_d = SYNC;
            end
        end else if (gap_q == 32'(TIMEOUT - 1)) begin
            // This edge is the TIMEOUT-th consecutive clock without a change.
            stall_d = 1'b1;
            state_d = SYNC;
            run_d   = '0;
            gap_d   = '0;
        end else begin
            gap_d = gap_q + 32'd1;
        end
    end

    // Output decode. Every source is a register, so outputs change on the
    // edge that samples the causing count_in value.
    always_comb begin
        locked     = (state_q == LOCK_UP) || (state_q == LOCK_DOWN);
        dir_up     = (state_q == LOCK_UP);
        dir_down   = (state_q == LOCK_DOWN);
        step_err   = step_err_q;
        stall      = stall_q;
        swap_seen  = swap_q;
        err_count  = err_q;
        last_value = last_q;
    end

endmodule

// File: tb/tb_counter_stream_monitor.sv
// ---------------------------------------------------------------------------
// Directed testbench for counter_stream_monitor (WIDTH=4, LOCK_STEPS=3,
// TIMEOUT=16). Inputs change on the falling edge. Outputs are sampled 1 ns
// after the rising edge that consumed the input.
// ---------------------------------------------------------------------------
module tb_counter_stream_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count_in = 4'h0;
    logic       decouple = 1'b0;
    logic       locked, dir_up, dir_down, step_err, stall, swap_seen;
    logic [7:0] err_count;
    logic [3:0] last_value;

    int n_checks = 0;
    int n_fail   = 0;

    counter_stream_monitor #(
        .WIDTH(4), .LOCK_STEPS(3), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .decouple(decouple),
        .locked(locked), .dir_up(dir_up), .dir_down(dir_down),
        .step_err(step_err), .stall(stall), .swap_seen(swap_seen),
        .err_count(err_count), .last_value(last_value)
    );

    always #5 clk = ~clk;

    // Present one value for one clock, then sample the outputs.
    task automatic tick(input logic [3:0] v);
        @(negedge clk);
        count_in = v;
        @(posedge clk);
        #1;
        $display("t=%0t in=%h dec=%b lock=%b up=%b dn=%b err=%b stall=%b swap=%b cnt=%0d last=%h",
                 $time, v, decouple, locked, dir_up, dir_down, step_err, stall, swap_seen,
                 err_count, last_value);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({locked, dir_up, dir_down, step_err, stall, swap_seen} !== 6'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 000000", {locked, dir_up, dir_down, step_err, stall, swap_seen}); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL reset_err_count: got %h want 00", err_count); end
        n_checks++; if (last_value !== 4'h0) begin n_fail++; $display("FAIL reset_last_value: got %h want 0", last_value); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 0,1,2,3 held four clocks each: the lock happens on the edge that samples 3.
    task automatic test_lock_up();
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4; k++) begin
                tick(4'(v));
                if (k == 0 && v == 2) begin
                    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_up_early: got %b want 0", locked); end
                end
                if (k == 0 && v == 3) begin
                    n_checks++; if ({locked, dir_up, dir_down} !== 3'b110) begin n_fail++; $display("FAIL lock_up_at_3: got %b want 110", {locked, dir_up, dir_down}); end
                end
            end
        end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL lock_up_err_count: got %h want 00", err_count); end
        n_checks++; if (last_value !== 4'h3) begin n_fail++; $display("FAIL lock_up_last_value: got %h want 3", last_value); end
    endtask

    // Continue 4..D while locked, then E,F,0,1 across the wrap.
    task automatic test_wrap();
        logic [3:0] seq [4];
        seq = '{4'hE, 4'hF, 4'h0, 4'h1};
        for (int v = 4; v <= 13; v++) tick(4'(v));
        for (int i = 0; i < 4; i++) begin
            tick(seq[i]);
            n_checks++; if ({dir_up, step_err} !== 2'b10) begin n_fail++; $display("FAIL wrap_%h: got up/err=%b want 10", seq[i], {dir_up, step_err}); end
        end
    endtask

    // Locked up at 5, then 4,3,2: swap on 4, relock down on 2.
    task automatic test_swap();
        for (int v = 2; v <= 5; v++) tick(4'(v));
        n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL swap_pre_up: got %b want 1", dir_up); end
        tick(4'h4);
        n_checks++; if ({swap_seen, locked, step_err} !== 3'b100) begin n_fail++; $display("FAIL swap_at_4: got swap/lock/err=%b want 100", {swap_seen, locked, step_err}); end
        tick(4'h3);
        n_checks++; if ({swap_seen, locked} !== 2'b00) begin n_fail++; $display("FAIL swap_at_3: got swap/lock=%b want 00", {swap_seen, locked}); end
        tick(4'h2);
        n_checks++; if ({locked, dir_up, dir_down} !== 3'b101) begin n_fail++; $display("FAIL swap_relock_down: got %b want 101", {locked, dir_up, dir_down}); end
    endtask

    // Get locked up at 7, then jump to B, then C,D (unlocked), E (locked).
    task automatic test_bad_jump();
        for (int v = 3; v <= 7; v++) tick(4'(v));
        n_checks++; if (dir_up !== 1'b1) begin n_fail++; $display("FAIL bad_pre_up: got %b want 1", dir_up); end
        tick(4'hB);
        n_checks++; if ({step_err, locked} !== 2'b10) begin n_fail++; $display("FAIL bad_jump: got err/lock=%b want 10", {step_err, locked}); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL bad_err_count: got %0d want 1", err_count); end
        tick(4'hB);
        n_checks++; if (step_err !== 1'b0) begin n_fail++; $display("FAIL bad_pulse_width: got %b want 0", step_err); end
        tick(4'hC);
        tick(4'hD);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL bad_run2_unlocked: got %b want 0", locked); end
        tick(4'hE);
        n_checks++; if ({locked, dir_up} !== 2'b11) begin n_fail++; $display("FAIL bad_relock_up: got %b want 11", {locked, dir_up}); end
    endtask

    // Locked at E with gap 0. The 16th unchanged clock fires the stall.
    task automatic test_stall();
        int pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            tick(4'hE);
            if (stall) pulses++;
        end
        n_checks++; if ({stall, locked} !== 2'b10) begin n_fail++; $display("FAIL stall_on_16th: got stall/lock=%b want 10", {stall, locked}); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL stall_pulse_count: got %0d want 1", pulses); end
        n_checks++; if (last_value !== 4'hE) begin n_fail++; $display("FAIL stall_last_value: got %h want E", last_value); end
        // 15 quiet clocks: no second stall. A change on the 16th counts as a change.
        pulses = 0;
        for (int k = 1; k <= 15; k++) begin
            tick(4'hE);
            if (stall) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL stall_second_pulse: got %0d want 0", pulses); end
        tick(4'hF);
        n_checks++; if ({stall, step_err} !== 2'b00) begin n_fail++; $display("FAIL stall_change_wins: got stall/err=%b want 00", {stall, step_err}); end
    endtask

    // Lock down at 9, decouple 10 clocks with noise, then baseline 2 and lock at 5.
    task automatic test_decouple();
        int pulses = 0;
        for (int v = 14; v >= 9; v--) tick(4'(v));
        n_checks++; if ({locked, dir_down} !== 2'b11) begin n_fail++; $display("FAIL dec_pre_down: got %b want 11", {locked, dir_down}); end
        decouple = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(4'($urandom_range(15)));
            if (step_err || stall || swap_seen || locked) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL dec_activity: got %0d active clocks want 0", pulses); end
        n_checks++; if ({last_value, err_count} !== {4'h9, 8'd1}) begin n_fail++; $display("FAIL dec_held: got last=%h cnt=%0d want 9/1", last_value, err_count); end
        decouple = 1'b0;
        tick(4'h2);
        n_checks++; if ({step_err, locked, last_value} !== {2'b00, 4'h2}) begin n_fail++; $display("FAIL dec_baseline: got err=%b lock=%b last=%h want 0/0/2", step_err, locked, last_value); end
        tick(4'h3);
        tick(4'h4);
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL dec_run2_unlocked: got %b want 0", locked); end
        tick(4'h5);
        n_checks++; if ({locked, dir_up} !== 2'b11) begin n_fail++; $display("FAIL dec_lock_at_5: got %b want 11", {locked, dir_up}); end
    endtask

    // 256 jumps of +2 are all illegal: err_count goes 1 -> 201 -> saturates at FF.
    task automatic test_saturate();
        logic [3:0] v = 4'h5;
        for (int k = 1; k <= 256; k++) begin
            v = v + 4'd2;
            tick(v);
            if (k == 200) begin
                n_checks++; if (err_count !== 8'd201) begin n_fail++; $display("FAIL sat_mid: got %0d want 201", err_count); end
            end
        end
        n_checks++; if (err_count !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %h want FF", err_count); end
    endtask

    // Reset asserted between edges clears state without waiting for a clock.
    task automatic test_async_reset();
        tick(4'h6);
        tick(4'h7);
        tick(4'h8);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL areset_pre_lock: got %b want 1", locked); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if ({locked, err_count, last_value} !== 13'b0) begin n_fail++; $display("FAIL areset_clear: got lock=%b cnt=%h last=%h want all 0", locked, err_count, last_value); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_wrap();
        test_swap();
        test_bad_jump();
        test_stall();
        test_decouple();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
